// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp encodings, the ID/EX control
// bundle and the bubble counter width.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd54;
   localparam logic [5:0] OP_SW    = 6'd39;
   localparam logic [5:0] OP_LW    = 6'd40;
   localparam logic [5:0] OP_ADDI  = 6'd41;
   localparam logic [5:0] OP_SUBI  = 6'd42;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_RTYPE = 3'b010;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic       memRead;
      logic       memtoReg;
      logic       memWrite;
      logic       aluSrc;
      logic       regWrite;
      logic [2:0] aluOp;
   } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction sitting in ID.
module hazard_detect (
   input  logic       exValid,
   input  logic       exMemRead,
   input  logic [4:0] exDst,
   input  logic       idValid,
   input  logic       idRegDst,
   input  logic       idMemWrite,
   input  logic [4:0] idRs,
   input  logic [4:0] idRt,
   output logic       loadUse
);

   logic rtIsSource;

   // rt is only a source for R-type (RegDst) and store (store data) forms.
   assign rtIsSource = idRegDst | idMemWrite;

   assign loadUse = exValid & exMemRead & (exDst != 5'd0) & idValid &
                    ((exDst == idRs) | (rtIsSource & (exDst == idRt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, downstream stall and optional load-use
// interlock (enabled by defining ID_EX_HAZARD_EN).
module id_ex_stage
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_RegDst,
   input  logic             id_MemRead,
   input  logic             id_MemtoReg,
   input  logic             id_MemWrite,
   input  logic             id_ALUSrc,
   input  logic             id_RegWrite,
   input  logic [2:0]       id_ALUOp,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic [31:0]      id_rs_data,
   input  logic [31:0]      id_rt_data,
   input  logic [15:0]      id_imm,
   input  logic [5:0]       id_funct,
   input  logic             flush,
   input  logic             ex_stall,
   output logic             ex_valid,
   output logic             ex_MemRead,
   output logic             ex_MemtoReg,
   output logic             ex_MemWrite,
   output logic             ex_ALUSrc,
   output logic             ex_RegWrite,
   output logic [2:0]       ex_ALUOp,
   output logic [31:0]      ex_rs_data,
   output logic [31:0]      ex_rt_data,
   output logic [31:0]      ex_imm32,
   output logic [5:0]       ex_funct,
   output logic [4:0]       ex_dst,
   output logic             id_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Handshake: id_stall is the inverse of "ready" toward IF/ID. The decode slot
   // is consumed on a rising edge only when id_stall=0; flush wins over both stalls.
   ctrl_t            idCtrl;
   ctrl_t            exCtrl;
   logic             loadUse;
   logic [CNT_W-1:0] bubbleCnt;

   assign idCtrl = '{memRead:  id_MemRead,
                     memtoReg: id_MemtoReg,
                     memWrite: id_MemWrite,
                     aluSrc:   id_ALUSrc,
                     regWrite: id_RegWrite,
                     aluOp:    id_ALUOp};

`ifdef ID_EX_HAZARD_EN
   hazard_detect uHazard (
      .exValid    (ex_valid),
      .exMemRead  (exCtrl.memRead),
      .exDst      (ex_dst),
      .idValid    (id_valid),
      .idRegDst   (id_RegDst),
      .idMemWrite (id_MemWrite),
      .idRs       (id_rs),
      .idRt       (id_rt),
      .loadUse    (loadUse)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubbleCnt <= '0;
      else if (!flush && !ex_stall && loadUse && bubbleCnt != CNT_MAX)
         bubbleCnt <= bubbleCnt + 1'b1;
   end
`else
   logic unusedRs;

   // Without the interlock the source register number has no consumer.
   assign unusedRs  = ^id_rs;
   assign loadUse   = 1'b0;
   assign bubbleCnt = '0;
`endif

   assign id_stall   = rst_n & ~flush & (ex_stall | loadUse);
   assign bubble_cnt = bubbleCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         exCtrl     <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm32   <= '0;
         ex_funct   <= '0;
         ex_dst     <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         exCtrl   <= '0;
      end else if (ex_stall) begin
         ex_valid <= ex_valid;
      end else if (loadUse) begin
         ex_valid <= 1'b0;
         exCtrl   <= '0;
      end else begin
         ex_valid   <= id_valid;
         exCtrl     <= id_valid ? idCtrl : '0;
         ex_rs_data <= id_rs_data;
         ex_rt_data <= id_rt_data;
         ex_imm32   <= {{16{id_imm[15]}}, id_imm};
         ex_funct   <= id_funct;
         ex_dst     <= id_RegDst ? id_rd : id_rt;
      end
   end

   assign ex_MemRead  = exCtrl.memRead;
   assign ex_MemtoReg = exCtrl.memtoReg;
   assign ex_MemWrite = exCtrl.memWrite;
   assign ex_ALUSrc   = exCtrl.aluSrc;
   assign ex_RegWrite = exCtrl.regWrite;
   assign ex_ALUOp    = exCtrl.aluOp;

endmodule
